reg_file_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the 8 x 16-bit register-file datapath (3-bit write/read addresses, one write enable, two read ports).
- Accepts one 16-bit instruction per handshake, then drives rd_addr_a, rd_addr_b, wr_addr, wr_E, ALU control and memory request for the correct number of cycles.
- Sits between the fetch stage and the register file / ALU / data-memory interface.

---
 rtl/reg_file_seq_pkg.sv | 51 +++++
 rtl/reg_file_seq_decode.sv | 45 ++++
 rtl/reg_file_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_reg_file_seq_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_seq_pkg.sv
// Shared encodings for the register-file sequencer: instruction fields, opcodes,
// ALU operations and controller states.
package reg_file_seq_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned IMM_W    = 6;
  localparam int unsigned TMO_W    = 4;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RSA_LSB = 6;
  localparam int unsigned RSB_LSB = 3;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MEM  = 3'd2,
    ST_WB   = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  function automatic logic [INSTR_W-1:0] zext_imm(input logic [IMM_W-1:0] imm6);
    return INSTR_W'(imm6);
  endfunction

endpackage

// File: rtl/reg_file_seq_decode.sv
// Combinational opcode decode: instruction class flags and ALU control.
module reg_file_seq_decode
  import reg_file_seq_pkg::*;
(
  input  logic [INSTR_W-1:0]  instr,
  output logic                writes_rd,
  output logic                is_mem,
  output logic                is_store,
  output logic                is_halt,
  output logic                is_illegal,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_b_sel
);

  logic [OPC_W-1:0] opc;
  logic             unused_fields;

  assign opc           = instr[OPC_LSB +: OPC_W];
  assign unused_fields = ^instr[OPC_LSB-1:0];

  always_comb begin
    writes_rd  = 1'b0;
    is_mem     = 1'b0;
    is_store   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    alu_op     = ALU_ADD;
    alu_b_sel  = 1'b0;
    case (opc)
      OP_NOP:  ;
      OP_ADD:  writes_rd = 1'b1;
      OP_SUB:  begin writes_rd = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin writes_rd = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin writes_rd = 1'b1; alu_op = ALU_OR;  end
      OP_XOR:  begin writes_rd = 1'b1; alu_op = ALU_XOR; end
      OP_ADDI: begin writes_rd = 1'b1; alu_b_sel = 1'b1; end
      // LD/ST reuse the ADD-with-immediate path to form the address
      OP_LD:   begin writes_rd = 1'b1; is_mem = 1'b1; alu_b_sel = 1'b1; end
      OP_ST:   begin is_mem = 1'b1; is_store = 1'b1; alu_b_sel = 1'b1; end
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_file_seq_ctrl.sv
// Multi-cycle sequencer driving the 8x16 register file, ALU and data memory.
// Optional REG_FILE_SEQ_R0_ZERO_EN: suppress writes to register 0.
module reg_file_seq_ctrl
  import reg_file_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RET_W       = 16
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                mem_ack,
  output logic [REG_AW-1:0]   rd_addr_a,
  output logic [REG_AW-1:0]   rd_addr_b,
  output logic [REG_AW-1:0]   wr_addr,
  output logic                wr_E,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_b_sel,
  output logic [INSTR_W-1:0]  imm,
  output logic                wb_sel,
  output logic                mem_req,
  output logic                mem_we,
  output logic                halted,
  output logic                illegal,
  output logic                mem_err,
  output logic [RET_W-1:0]    retired
);

  state_e               state_q, state_nxt;
  logic [TMO_W-1:0]     tmo_q, tmo_nxt;
  logic                 is_mem_q, is_mem_nxt;
  logic                 is_store_q, is_store_nxt;

  logic                 instr_ready_nxt, wr_e_nxt, alu_b_sel_nxt, wb_sel_nxt;
  logic                 mem_req_nxt, mem_we_nxt, halted_nxt, illegal_nxt, mem_err_nxt;
  logic [REG_AW-1:0]    rd_addr_a_nxt, rd_addr_b_nxt, wr_addr_nxt;
  logic [ALU_OP_W-1:0]  alu_op_nxt;
  logic [INSTR_W-1:0]   imm_nxt;
  logic [RET_W-1:0]     retired_nxt;

  logic                 dec_writes_rd, dec_is_mem, dec_is_store, dec_is_halt, dec_is_illegal;
  logic [ALU_OP_W-1:0]  dec_alu_op;
  logic                 dec_alu_b_sel;
  logic                 hs;
  logic                 wr_block;

  reg_file_seq_decode u_decode (
    .instr      (instr),
    .writes_rd  (dec_writes_rd),
    .is_mem     (dec_is_mem),
    .is_store   (dec_is_store),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal),
    .alu_op     (dec_alu_op),
    .alu_b_sel  (dec_alu_b_sel)
  );

  assign hs = instr_valid & instr_ready;

`ifdef REG_FILE_SEQ_R0_ZERO_EN
  assign wr_block = (wr_addr == '0);
`else
  assign wr_block = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      is_mem_q    <= 1'b0;
      is_store_q  <= 1'b0;
      instr_ready <= 1'b1;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      wr_addr     <= '0;
      wr_E        <= 1'b0;
      alu_op      <= '0;
      alu_b_sel   <= 1'b0;
      imm         <= '0;
      wb_sel      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      mem_err     <= 1'b0;
      retired     <= '0;
    end else begin
      state_q     <= state_nxt;
      tmo_q       <= tmo_nxt;
      is_mem_q    <= is_mem_nxt;
      is_store_q  <= is_store_nxt;
      instr_ready <= instr_ready_nxt;
      rd_addr_a   <= rd_addr_a_nxt;
      rd_addr_b   <= rd_addr_b_nxt;
      wr_addr     <= wr_addr_nxt;
      wr_E        <= wr_e_nxt;
      alu_op      <= alu_op_nxt;
      alu_b_sel   <= alu_b_sel_nxt;
      imm         <= imm_nxt;
      wb_sel      <= wb_sel_nxt;
      mem_req     <= mem_req_nxt;
      mem_we      <= mem_we_nxt;
      halted      <= halted_nxt;
      illegal     <= illegal_nxt;
      mem_err     <= mem_err_nxt;
      retired     <= retired_nxt;
    end
  end

  // Next state plus next value of every registered output
  always_comb begin
    state_nxt     = state_q;
    tmo_nxt       = '0;
    is_mem_nxt    = is_mem_q;
    is_store_nxt  = is_store_q;
    rd_addr_a_nxt = rd_addr_a;
    rd_addr_b_nxt = rd_addr_b;
    wr_addr_nxt   = wr_addr;
    alu_op_nxt    = alu_op;
    alu_b_sel_nxt = alu_b_sel;
    imm_nxt       = imm;
    wb_sel_nxt    = 1'b0;
    halted_nxt    = halted;
    illegal_nxt   = illegal;
    mem_err_nxt   = mem_err;
    retired_nxt   = retired;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (dec_is_illegal) begin
            illegal_nxt = 1'b1;
          end else if (dec_is_halt) begin
            state_nxt   = ST_HALT;
            halted_nxt  = 1'b1;
            retired_nxt = retired + RET_W'(1);
          end else if (dec_writes_rd || dec_is_mem) begin
            state_nxt     = ST_EXEC;
            is_mem_nxt    = dec_is_mem;
            is_store_nxt  = dec_is_store;
            rd_addr_a_nxt = instr[RSA_LSB +: REG_AW];
            rd_addr_b_nxt = instr[RSB_LSB +: REG_AW];
            wr_addr_nxt   = instr[RD_LSB +: REG_AW];
            alu_op_nxt    = dec_alu_op;
            alu_b_sel_nxt = dec_alu_b_sel;
            imm_nxt       = zext_imm(instr[IMM_LSB +: IMM_W]);
          end else begin
            retired_nxt = retired + RET_W'(1);
          end
        end
      end
      ST_EXEC: state_nxt = is_mem_q ? ST_MEM : ST_WB;
      ST_MEM: begin
        // An ack on the final allowed cycle still wins over the timeout
        if (mem_ack) begin
          if (is_store_q) begin
            state_nxt   = ST_IDLE;
            retired_nxt = retired + RET_W'(1);
          end else begin
            state_nxt  = ST_WB;
            wb_sel_nxt = 1'b1;
          end
        end else if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
          state_nxt   = ST_IDLE;
          mem_err_nxt = 1'b1;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        state_nxt   = ST_IDLE;
        retired_nxt = retired + RET_W'(1);
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase

    instr_ready_nxt = (state_nxt == ST_IDLE);
    mem_req_nxt     = (state_nxt == ST_MEM);
    mem_we_nxt      = (state_nxt == ST_MEM) && is_store_q;
    wr_e_nxt        = (state_nxt == ST_WB) && !wr_block;
  end

endmodule

// File: tb/tb_reg_file_seq_ctrl.sv
// Directed bench for reg_file_seq_ctrl; honours REG_FILE_SEQ_R0_ZERO_EN when defined.
module tb_reg_file_seq_ctrl;

  logic        CLK;
  logic        CLR_N;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_ack;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic        wr_E;
  logic [2:0]  alu_op;
  logic        alu_b_sel;
  logic [15:0] imm;
  logic        wb_sel, mem_req, mem_we, halted, illegal, mem_err;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  int n;
  logic wr_seen;

  reg_file_seq_ctrl dut (
    .CLK         (CLK),
    .CLR_N       (CLR_N),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .mem_ack     (mem_ack),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .wr_addr     (wr_addr),
    .wr_E        (wr_E),
    .alu_op      (alu_op),
    .alu_b_sel   (alu_b_sel),
    .imm         (imm),
    .wb_sel      (wb_sel),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .halted      (halted),
    .illegal     (illegal),
    .mem_err     (mem_err),
    .retired     (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic issue(input logic [15:0] word);
    instr       = word;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    CLR_N = 1'b0; instr = '0; instr_valid = 1'b0; mem_ack = 1'b0;
    step(); step();
    CLR_N = 1'b1;
    chk("rst_ready",   32'(instr_ready), 32'd1);
    chk("rst_retired", 32'(retired),     32'd0);
    chk("rst_wr_e",    32'(wr_E),        32'd0);
    chk("rst_halted",  32'(halted),      32'd0);

    // ADD r3 = r1 + r2
    issue(16'h1650);
    chk("add_exec_ready", 32'(instr_ready), 32'd0);
    chk("add_exec_ra",    32'(rd_addr_a),   32'd1);
    chk("add_exec_rb",    32'(rd_addr_b),   32'd2);
    chk("add_exec_op",    32'(alu_op),      32'd0);
    chk("add_exec_bsel",  32'(alu_b_sel),   32'd0);
    chk("add_exec_wr_e",  32'(wr_E),        32'd0);
    step();
    chk("add_wb_wr_e",    32'(wr_E),        32'd1);
    chk("add_wb_waddr",   32'(wr_addr),     32'd3);
    chk("add_wb_sel",     32'(wb_sel),      32'd0);
    step();
    chk("add_done_wr_e",  32'(wr_E),        32'd0);
    chk("add_retired",    32'(retired),     32'd1);
    chk("add_done_ready", 32'(instr_ready), 32'd1);

    // LD r5 = mem[r2 + 4], ack in the third MEM cycle
    issue(16'h7A84);
    chk("ld_exec_bsel", 32'(alu_b_sel), 32'd1);
    chk("ld_exec_imm",  32'(imm),       32'd4);
    chk("ld_exec_ra",   32'(rd_addr_a), 32'd2);
    chk("ld_exec_req",  32'(mem_req),   32'd0);
    step();
    chk("ld_mem_we",    32'(mem_we),    32'd0);
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      if (n == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("ld_req_cycles", 32'(n),       32'd3);
    chk("ld_wb_wr_e",    32'(wr_E),    32'd1);
    chk("ld_wb_waddr",   32'(wr_addr), 32'd5);
    chk("ld_wb_sel",     32'(wb_sel),  32'd1);
    step();
    chk("ld_retired",    32'(retired), 32'd2);

    // ST with no ack: abort after 15 MEM cycles
    issue(16'h8058);
    step();
    chk("st_mem_we",  32'(mem_we),  32'd1);
    chk("st_mem_err", 32'(mem_err), 32'd0);
    n = 0; wr_seen = 1'b0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      if (wr_E) wr_seen = 1'b1;
      step();
    end
    chk("st_req_cycles",  32'(n),           32'd15);
    chk("st_mem_err_set", 32'(mem_err),     32'd1);
    chk("st_no_write",    32'(wr_seen),     32'd0);
    chk("st_retired",     32'(retired),     32'd2);
    chk("st_ready",       32'(instr_ready), 32'd1);

    // Reset in the middle of a memory request
    issue(16'h7A84);
    step();
    chk("rst_mem_req_pre", 32'(mem_req), 32'd1);
    CLR_N = 1'b0;
    step();
    CLR_N = 1'b1;
    chk("rst_mem_req",   32'(mem_req),     32'd0);
    chk("rst_mem_err",   32'(mem_err),     32'd0);
    chk("rst_retired2",  32'(retired),     32'd0);
    chk("rst_ready2",    32'(instr_ready), 32'd1);
    chk("rst_bsel",      32'(alu_b_sel),   32'd0);
    chk("rst_imm",       32'(imm),         32'd0);

    // Stray ack while idle
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_ready", 32'(instr_ready), 32'd1);
    chk("idle_ack_req",   32'(mem_req),     32'd0);

    // LD acked on the last allowed MEM cycle succeeds
    issue(16'h7A84);
    step();
    repeat (14) step();
    chk("edge_req",     32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("edge_wr_e",    32'(wr_E),    32'd1);
    chk("edge_wb_sel",  32'(wb_sel),  32'd1);
    chk("edge_mem_err", 32'(mem_err), 32'd0);
    step();
    chk("edge_retired", 32'(retired), 32'd1);

    // NOP retires in IDLE
    issue(16'h0000);
    chk("nop_retired", 32'(retired),     32'd2);
    chk("nop_ready",   32'(instr_ready), 32'd1);

    // Illegal opcode
    issue(16'hA000);
    chk("ill_flag",    32'(illegal),     32'd1);
    chk("ill_retired", 32'(retired),     32'd2);
    chk("ill_ready",   32'(instr_ready), 32'd1);

    // XOR r7 = r4 ^ r6
    issue(16'h5F30);
    chk("xor_op", 32'(alu_op),    32'd4);
    chk("xor_ra", 32'(rd_addr_a), 32'd4);
    chk("xor_rb", 32'(rd_addr_b), 32'd6);
    step();
    chk("xor_wr_e",  32'(wr_E),    32'd1);
    chk("xor_waddr", 32'(wr_addr), 32'd7);
    step();
    chk("xor_retired", 32'(retired), 32'd3);

    // ADDI r0 = r0 + 5
    issue(16'h6005);
    chk("addi_bsel", 32'(alu_b_sel), 32'd1);
    chk("addi_imm",  32'(imm),       32'd5);
    chk("addi_op",   32'(alu_op),    32'd0);
    step();
`ifdef REG_FILE_SEQ_R0_ZERO_EN
    chk("addi_r0_wr_e", 32'(wr_E), 32'd0);
`else
    chk("addi_r0_wr_e", 32'(wr_E), 32'd1);
`endif
    chk("addi_waddr", 32'(wr_addr), 32'd0);
    step();
    chk("addi_retired", 32'(retired), 32'd4);

    // HALT, then an ADD that must not be taken
    issue(16'hF000);
    chk("halt_flag",    32'(halted),      32'd1);
    chk("halt_ready",   32'(instr_ready), 32'd0);
    chk("halt_retired", 32'(retired),     32'd5);
    instr = 16'h1650; instr_valid = 1'b1;
    repeat (4) step();
    instr_valid = 1'b0;
    chk("halt_hold_ready",   32'(instr_ready), 32'd0);
    chk("halt_hold_retired", 32'(retired),     32'd5);
    chk("halt_hold_wr_e",    32'(wr_E),        32'd0);
    chk("halt_hold_ill",     32'(illegal),     32'd1);

    // Reset leaves HALT
    CLR_N = 1'b0;
    step();
    CLR_N = 1'b1;
    chk("unhalt_halted", 32'(halted),      32'd0);
    chk("unhalt_ready",  32'(instr_ready), 32'd1);
    chk("unhalt_ill",    32'(illegal),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
